// File: rtl/hit_bool_pkg.sv
// Shared types for the hit_bool triangle scheduler.
package hit_bool_pkg;

  localparam int COORD_W = 32;
  localparam int Q_BITS  = 16;

  typedef logic signed [2:0][COORD_W-1:0] vec3_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/hit_bool_ctrl.sv
// Per-ray scheduler: streams triangles into hit_bool and
// reduces the returned hit flags to a single ray summary.
module hit_bool_ctrl
  import hit_bool_pkg::*;
#(
  parameter int TRI_ADDR_W = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [TRI_ADDR_W-1:0] tri_count,
  output logic                  busy,
  output logic                  tri_rd_en,
  output logic [TRI_ADDR_W-1:0] tri_addr,
  input  logic [3*DATA_W-1:0]   tri_v0,
  input  logic [3*DATA_W-1:0]   tri_v1,
  input  logic [3*DATA_W-1:0]   tri_v2,
  input  logic [3*DATA_W-1:0]   tri_normal,
  output logic [3*DATA_W-1:0]   v0,
  output logic [3*DATA_W-1:0]   v1,
  output logic [3*DATA_W-1:0]   v2,
  output logic [3*DATA_W-1:0]   normal,
  output logic                  v0_in_wr_en,
  output logic                  v1_in_wr_en,
  output logic                  v2_in_wr_en,
  output logic                  normal_in_wr_en,
  input  logic                  v0_in_full,
  input  logic                  v1_in_full,
  input  logic                  v2_in_full,
  input  logic                  normal_in_full,
  input  logic                  fifo_out_dout,
  input  logic                  fifo_out_empty,
  output logic                  fifo_out_rd_en,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  result_hit,
  output logic [TRI_ADDR_W-1:0] result_idx
);

  localparam int CW = TRI_ADDR_W + 1;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] res_q, res_d;

  logic [TRI_ADDR_W-1:0] addr_q, addr_d;
  logic [TRI_ADDR_W-1:0] idx_q, idx_d;

  logic hit_q, hit_d;
  logic valid_q, valid_d;

  logic [3*DATA_W-1:0] v0_q, v0_d;
  logic [3*DATA_W-1:0] v1_q, v1_d;
  logic [3*DATA_W-1:0] v2_q, v2_d;
  logic [3*DATA_W-1:0] nrm_q, nrm_d;

  logic any_full;
  logic collect;
  logic rd;
  logic wr;
  logic take;

  assign any_full = v0_in_full | v1_in_full |
                    v2_in_full | normal_in_full;

  assign collect = (state_q == FETCH) |
                   (state_q == WAIT)  |
                   (state_q == ISSUE) |
                   (state_q == DRAIN);

  assign rd = collect & ~fifo_out_empty;
  assign wr = (state_q == ISSUE) & ~any_full;

  // Reads beyond the issue count are drained but not counted.
  assign take = rd & (res_q < iss_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    res_d   = res_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    valid_d = valid_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    nrm_d   = nrm_q;

    if (take) begin
      res_d = res_q + CW'(1);
      if (fifo_out_dout && !hit_q) begin
        hit_d = 1'b1;
        idx_d = res_q[TRI_ADDR_W-1:0];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = {1'b0, tri_count};
          iss_d = '0;
          res_d = '0;
          hit_d = 1'b0;
          idx_d = '0;
          if (tri_count == '0) begin
            state_d = DONE;
            valid_d = 1'b1;
          end else begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        v0_d    = tri_v0;
        v1_d    = tri_v1;
        v2_d    = tri_v2;
        nrm_d   = tri_normal;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (wr) begin
          iss_d = iss_q + CW'(1);
          if (iss_d == cnt_q) begin
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
            addr_d  = iss_d[TRI_ADDR_W-1:0];
          end
        end
      end
      DRAIN: begin
        if (res_d == cnt_q) begin
          state_d = DONE;
          valid_d = 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iss_q   <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      nrm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      valid_q <= valid_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      nrm_q   <= nrm_d;
    end
  end

  // hit_bool never returns more results than were issued.
  a_res_le_iss: assert property (
    @(posedge clock) disable iff (reset)
    rd |-> (res_q < iss_q)
  );

  assign busy            = (state_q != IDLE);
  assign tri_rd_en       = (state_q == FETCH);
  assign tri_addr        = addr_q;
  assign v0              = v0_q;
  assign v1              = v1_q;
  assign v2              = v2_q;
  assign normal          = nrm_q;
  assign v0_in_wr_en     = wr;
  assign v1_in_wr_en     = wr;
  assign v2_in_wr_en     = wr;
  assign normal_in_wr_en = wr;
  assign fifo_out_rd_en  = rd;
  assign result_valid    = valid_q;
  assign result_hit      = hit_q;
  assign result_idx      = idx_q;

endmodule

// File: tb/tb_hit_bool_ctrl.sv
// Scoreboard bench for hit_bool_ctrl with memory and
// hit_bool FIFO models driven by directed ray vectors.
module tb_hit_bool_ctrl;
  import hit_bool_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 3 * DW;

  typedef struct packed {
    logic          hit;
    logic [AW-1:0] idx;
  } sum_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] tri_count = '0;
  logic          busy, tri_rd_en;
  logic [AW-1:0] tri_addr;
  logic [BW-1:0] tri_v0 = '0, tri_v1 = '0;
  logic [BW-1:0] tri_v2 = '0, tri_normal = '0;
  logic [BW-1:0] v0, v1, v2, normal;
  logic          v0_in_wr_en, v1_in_wr_en;
  logic          v2_in_wr_en, normal_in_wr_en;
  logic          v0_in_full = 1'b0, v1_in_full = 1'b0;
  logic          v2_in_full = 1'b0, normal_in_full = 1'b0;
  logic          fifo_out_dout = 1'b0;
  logic          fifo_out_empty = 1'b1;
  logic          fifo_out_rd_en;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic          result_hit;
  logic [AW-1:0] result_idx;

  hit_bool_ctrl #(.TRI_ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .tri_count(tri_count), .busy(busy),
    .tri_rd_en(tri_rd_en), .tri_addr(tri_addr),
    .tri_v0(tri_v0), .tri_v1(tri_v1),
    .tri_v2(tri_v2), .tri_normal(tri_normal),
    .v0(v0), .v1(v1), .v2(v2), .normal(normal),
    .v0_in_wr_en(v0_in_wr_en),
    .v1_in_wr_en(v1_in_wr_en),
    .v2_in_wr_en(v2_in_wr_en),
    .normal_in_wr_en(normal_in_wr_en),
    .v0_in_full(v0_in_full), .v1_in_full(v1_in_full),
    .v2_in_full(v2_in_full),
    .normal_in_full(normal_in_full),
    .fifo_out_dout(fifo_out_dout),
    .fifo_out_empty(fifo_out_empty),
    .fifo_out_rd_en(fifo_out_rd_en),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_hit(result_hit), .result_idx(result_idx)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_rd = 0;
  sum_t exp_q[$];
  int   wr_cyc[$];
  logic res_pat [0:15];
  logic rq[$];
  int   wptr = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Q16.16 coordinates, distinct per triangle/bus/lane.
  function automatic logic [BW-1:0] mem_word(int idx, int k);
    vec3_t v;
    for (int j = 0; j < 3; j++)
      v[j] = COORD_W'((idx * 16 + k * 4 + j - 5) <<< Q_BITS);
    return v;
  endfunction

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (tri_rd_en) begin
      tri_v0     <= mem_word(int'(tri_addr), 0);
      tri_v1     <= mem_word(int'(tri_addr), 1);
      tri_v2     <= mem_word(int'(tri_addr), 2);
      tri_normal <= mem_word(int'(tri_addr), 3);
    end
  end

  // hit_bool model: one result per write, one cycle later.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rq.delete();
      wptr = 0;
      fifo_out_empty <= 1'b1;
      fifo_out_dout  <= 1'b0;
    end else begin
      if (start && !busy) wptr = 0;
      if (fifo_out_rd_en && rq.size() > 0)
        void'(rq.pop_front());
      if (v0_in_wr_en) begin
        rq.push_back(res_pat[wptr % 16]);
        wptr++;
      end
      fifo_out_empty <= (rq.size() == 0);
      fifo_out_dout  <= (rq.size() > 0) ? rq[0] : 1'b0;
    end
  end

  always @(negedge clock) begin
    if (v0_in_wr_en | v1_in_wr_en |
        v2_in_wr_en | normal_in_wr_en) begin
      chk("wr_en_together",
          {v0_in_wr_en, v1_in_wr_en,
           v2_in_wr_en, normal_in_wr_en}, 4'hf);
      chk("wr_while_full",
          {v0_in_full, v1_in_full,
           v2_in_full, normal_in_full}, 4'h0);
      chk("bus_v0", v0, mem_word(wr_cyc.size(), 0));
      chk("bus_v1", v1, mem_word(wr_cyc.size(), 1));
      chk("bus_v2", v2, mem_word(wr_cyc.size(), 2));
      chk("bus_nrm", normal, mem_word(wr_cyc.size(), 3));
      wr_cyc.push_back(cyc);
    end
    if (tri_rd_en) n_rd++;
  end

  always @(negedge clock) begin
    sum_t e;
    if (result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        chk("result_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("result_hit", result_hit, e.hit);
        chk("result_idx", result_idx, e.idx);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic launch(int cnt, logic h, int i);
    sum_t s;
    s.hit = h;
    s.idx = AW'(i);
    wr_cyc.delete();
    exp_q.push_back(s);
    tri_count = AW'(cnt);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(int limit);
    int k = 0;
    while (!result_valid && k < limit) begin
      step();
      k++;
    end
    chk("valid_timeout", result_valid, 1'b1);
  endtask

  initial begin
    int rd0;
    logic [BW-1:0] snap;
    for (int i = 0; i < 16; i++) res_pat[i] = 1'b0;

    step(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_addr", tri_addr, '0);
    chk("rst_v0", v0, '0);
    reset = 1'b0;
    step(2);

    // three triangles, results false/true/true
    res_pat[0] = 1'b0;
    res_pat[1] = 1'b1;
    res_pat[2] = 1'b1;
    launch(3, 1'b1, 1);
    wait_valid(100);
    chk("t1_hit_live", result_hit, 1'b1);
    step();
    chk("t1_writes", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      chk("t1_gap0", wr_cyc[1] - wr_cyc[0], 3);
      chk("t1_gap1", wr_cyc[2] - wr_cyc[1], 3);
    end
    chk("t1_busy", busy, 1'b0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // empty ray
    rd0 = n_rd;
    launch(0, 1'b0, 0);
    chk("t2_done_next", result_valid, 1'b1);
    chk("t2_hit", result_hit, 1'b0);
    step();
    chk("t2_no_rd", n_rd - rd0, 0);
    chk("t2_no_wr", wr_cyc.size(), 0);
    chk("t2_busy", busy, 1'b0);

    // backpressure on v1 during triangle 0 issue
    res_pat[0] = 1'b1;
    res_pat[1] = 1'b0;
    v1_in_full = 1'b1;
    launch(2, 1'b1, 0);
    step(2);
    snap = v0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_wr", v0_in_wr_en, 1'b0);
      chk("t3_stall_bus", v0, snap);
      step();
    end
    chk("t3_no_wr_yet", wr_cyc.size(), 0);
    v1_in_full = 1'b0;
    wait_valid(100);
    step();
    chk("t3_writes", wr_cyc.size(), 2);
    chk("t3_sb_empty", exp_q.size(), 0);

    // all misses, downstream not ready for 10 cycles
    for (int i = 0; i < 16; i++) res_pat[i] = 1'b0;
    result_ready = 1'b0;
    launch(4, 1'b0, 0);
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", result_valid, 1'b1);
      chk("t4_hold_sum", {result_hit, result_idx}, '0);
      step();
    end
    result_ready = 1'b1;
    step();
    chk("t4_busy_drop", busy, 1'b0);
    chk("t4_valid_drop", result_valid, 1'b0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // reset in the middle of triangle 5 of 8
    for (int i = 0; i < 16; i++) res_pat[i] = 1'b1;
    launch(8, 1'b1, 0);
    begin
      int k = 0;
      while (wr_cyc.size() < 5 && k < 200) begin
        step();
        k++;
      end
    end
    chk("t5_five_writes", wr_cyc.size(), 5);
    step(2);
    chk("t5_in_issue_wr", v0_in_wr_en, 1'b1);
    chk("t5_addr_hold", tri_addr, AW'(5));
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_strobes",
        {tri_rd_en, v0_in_wr_en, v1_in_wr_en,
         v2_in_wr_en, normal_in_wr_en, fifo_out_rd_en},
        '0);
    chk("t5_addr", tri_addr, '0);
    chk("t5_bus_v0", v0, '0);
    chk("t5_bus_nrm", normal, '0);
    chk("t5_sum",
        {result_valid, result_hit, result_idx}, '0);
    step();
    reset = 1'b0;
    step();
    launch(1, 1'b1, 0);
    wait_valid(100);
    step();
    chk("t5_sb_empty", exp_q.size(), 0);

    // start pulses in WAIT and DONE are ignored
    for (int i = 0; i < 16; i++) res_pat[i] = 1'b0;
    res_pat[2] = 1'b1;
    result_ready = 1'b0;
    rd0 = n_rd;
    launch(3, 1'b1, 2);
    step();
    tri_count = AW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(100);
    chk("t6_writes", wr_cyc.size(), 3);
    chk("t6_reads", n_rd - rd0, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_still_done", {busy, result_valid}, 2'b11);
    result_ready = 1'b1;
    step();
    chk("t6_idle", busy, 1'b0);
    step();
    chk("t6_stay_idle", busy, 1'b0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
